// File: rtl/sym_code_pkg.sv
// Shared line-code symbol constants and decoder state encoding for the
// 2-bit literal symbol link receiver.
package sym_code_pkg;

  localparam logic [1:0] SYM_IDLE    = 2'h0;
  localparam logic [1:0] SYM_ZERO    = 2'h1;
  localparam logic [1:0] SYM_ILLEGAL = 2'h2;
  localparam logic [1:0] SYM_ONE     = 2'h3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    OUT   = 2'd2,
    ERR   = 2'd3
  } state_t;

endpackage

// File: rtl/sym_code_classify.sv
// Combinational symbol classifier: splits a line symbol into data/idle/illegal
// flags and the carried data bit.
module sym_code_classify
  import sym_code_pkg::*;
(
  input  logic [1:0] sym,
  output logic       is_data,
  output logic       data_bit,
  output logic       is_idle,
  output logic       is_illegal
);

  always_comb begin
    is_idle    = (sym == SYM_IDLE);
    is_illegal = (sym == SYM_ILLEGAL);
    is_data    = (sym == SYM_ZERO) || (sym == SYM_ONE);
    data_bit   = (sym == SYM_ONE);
  end

endmodule

// File: rtl/sym_code_decoder.sv
// Line-code receive decoder: deserialises data symbols LSB-first into words.
// Define SYM_CODE_DECODER_PARITY_EN to require a trailing even-parity symbol.
module sym_code_decoder
  import sym_code_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int IDLE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sym_valid,
  input  logic [1:0]       sym,
  output logic             sym_ready,
  output logic             word_valid,
  output logic [WIDTH-1:0] word,
  input  logic             word_ready,
  output logic             err,
  output logic [7:0]       err_cnt
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [3:0]       idle_cnt;

  logic is_data, data_bit, is_idle, is_illegal;
  logic accept, bit_wr, idle_inc, cnt_clr;

  sym_code_classify u_classify (
    .sym        (sym),
    .is_data    (is_data),
    .data_bit   (data_bit),
    .is_idle    (is_idle),
    .is_illegal (is_illegal)
  );

  assign accept = sym_valid && sym_ready;
  assign word   = shreg;

  always_comb begin
    state_nxt  = state;
    sym_ready  = 1'b0;
    word_valid = 1'b0;
    err        = 1'b0;
    bit_wr     = 1'b0;
    idle_inc   = 1'b0;
    cnt_clr    = 1'b0;
    case (state)
      IDLE: begin
        sym_ready = 1'b1;
        if (accept) begin
          if (is_data) begin
            bit_wr    = 1'b1;
            state_nxt = SHIFT;
          end else if (is_illegal) begin
            state_nxt = ERR;
          end
        end
      end
      SHIFT: begin
        sym_ready = 1'b1;
        if (accept) begin
          if (is_data) begin
`ifdef SYM_CODE_DECODER_PARITY_EN
            // bit_cnt == WIDTH means this symbol is the parity slot
            if (bit_cnt == CNT_W'(WIDTH)) begin
              if ((^shreg) ^ data_bit) begin
                state_nxt = ERR;
                cnt_clr   = 1'b1;
              end else begin
                state_nxt = OUT;
              end
            end else begin
              bit_wr = 1'b1;
            end
`else
            bit_wr = 1'b1;
            if (bit_cnt == CNT_W'(WIDTH - 1))
              state_nxt = OUT;
`endif
          end else if (is_idle) begin
            if (idle_cnt == 4'(IDLE_LIMIT - 1)) begin
              state_nxt = IDLE;
              cnt_clr   = 1'b1;
            end else begin
              idle_inc = 1'b1;
            end
          end else if (is_illegal) begin
            state_nxt = ERR;
            cnt_clr   = 1'b1;
          end
        end
      end
      OUT: begin
        word_valid = 1'b1;
        if (word_ready) begin
          state_nxt = IDLE;
          cnt_clr   = 1'b1;
        end
      end
      ERR: begin
        err       = 1'b1;
        state_nxt = IDLE;
        cnt_clr   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      idle_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      state <= state_nxt;
      for (int i = 0; i < WIDTH; i++)
        if (bit_wr && bit_cnt == CNT_W'(i))
          shreg[i] <= data_bit;
      if (cnt_clr) begin
        bit_cnt  <= '0;
        idle_cnt <= '0;
      end else if (bit_wr) begin
        bit_cnt  <= bit_cnt + 1'b1;
        idle_cnt <= '0;
      end else if (idle_inc) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
      // count on entry so err_cnt already reflects the error during the err pulse
      if (state_nxt == ERR && state != ERR && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
